free_list_checkpoint_ctrl: RTL
==============================

// Module: free_list_checkpoint_ctrl
// PURPOSE
//  Branch-checkpoint manager for the speculative free list in rename. Records the free-list head
//  for each dispatched branch in a circular checkpoint queue, tracks outstanding checkpoints, and
//  sequences the single-cycle recovery pulse (ctrlVerified/flagRecoverEX/headCp) into the free list
//  on a mispredict. Stalls rename when no checkpoint is free.
// PARAMETERS
//  NUM_CP       8   checkpoint entries; power of 2
//  CP_LOG       3   log2(NUM_CP)
//  FL_LOG       7   free-list index width (= SIZE_FREE_LIST_LOG)
// PORTS
//  clk               in   1       clock
//  reset             in   1       synchronous, active-low (0 = reset)
//  stall_i           in   1       rename stalled; no allocation this cycle
//  recoverFlag_i     in   1       commit-time full flush
//  brAlloc_i         in   1       branch in dispatch bundle requests checkpoint
//  headAtBranch_i    in   FL_LOG  free-list head to restore for that branch
//  resolveValid_i    in   1       branch resolved in EX
//  resolveTag_i      in   CP_LOG  checkpoint tag of resolved branch
//  mispredict_i      in   1       qualifies resolveValid_i: mispredicted
//  cpTag_o           out  CP_LOG  tag granted to brAlloc_i (= current tail)
//  cpFull_o          out  1       no free checkpoint; rename must stall
//  ctrlVerified_o    out  1       recovery pulse to free list
//  flagRecoverEX_o   out  1       recovery pulse to free list
//  freeListHeadCp_o  out  FL_LOG  head restored by free list
//  cpCount_o         out  CP_LOG+1 outstanding checkpoints
// BEHAVIOUR
//  - State: head, tail (CP_LOG, mod NUM_CP), cnt (CP_LOG+1), valid[NUM_CP], headRam[NUM_CP].
//  - Reset (reset==0 at posedge): head=tail=0, cnt=0, valid=0, all outputs 0; cpFull_o=0.
//  - cpFull_o = (cnt==NUM_CP), combinational. cpTag_o = tail, combinational.
//  - Alloc: brAlloc_i & ~stall_i & ~cpFull_o -> headRam[tail]=headAtBranch_i, valid[tail]=1,
//    tail++, cnt++. brAlloc_i while full or stalled: ignored, no state change.
//  - Correct resolve: resolveValid_i & ~mispredict_i & valid[tag] -> valid[tag]=0. Resolve on an
//    invalid tag: ignored.
//  - Retire: if cnt>0 & ~valid[head] -> head++, cnt--; at most one per cycle; uses this cycle's
//    pre-update valid. Same-cycle alloc+retire: cnt unchanged.
//  - Mispredict: resolveValid_i & mispredict_i & valid[T] -> next cycle (latency 1)
//    ctrlVerified_o=flagRecoverEX_o=1 for exactly one cycle, freeListHeadCp_o=headRam[T];
//    tail=T, valid[] of T and all younger (T..old tail-1, wrapping) cleared,
//    cnt=(T-head) mod NUM_CP computed width CP_LOG+1 (T==head -> 0). Retire suppressed that cycle.
//  - Priority: ~reset > recoverFlag_i > mispredict > alloc/retire. Same-cycle alloc and mispredict:
//    alloc dropped (it is younger). recoverFlag_i: head=tail=0, cnt=0, valid=0, pulse outputs 0,
//    pending recovery pulse cancelled.
//  - freeListHeadCp_o holds last restored value when pulse inactive; 0 after reset.
//  - Wrap-around: all tag arithmetic modulo NUM_CP; full/empty disambiguated only by cnt.
// STRUCTURE
//  - Shared defines header: NUM_CP, CP_LOG, FL_LOG (= SIZE_FREE_LIST_LOG); no new typedefs.
//  - Sub-module cp_head_ram: NUM_CP x FL_LOG, 1 async read (resolveTag_i), 1 sync write (tail);
//    reset-less. Pointer/valid/count logic and recovery pulse register stay in top.
// TESTING
//  1 Reset: hold reset=0 3 cycles -> cnt=0, cpFull_o=0, cpTag_o=0, pulse outputs 0.
//  2 Fill: 8 allocs, heads 10..17 -> cpTag_o 0..7, cpCount_o=8, cpFull_o=1; 9th alloc ignored.
//  3 Out-of-order resolve: resolve tags 2,1 correct -> head stays 0; resolve 0 -> head 1,2,3
//    over next 3 cycles, cnt 8->5.
//  4 Mispredict tag 5 (headRam=15, head=3, tail=0 wrapped) -> next cycle pulse 1 cycle,
//    freeListHeadCp_o=15, tail=5, cnt=2, valid[5..7]=0.
//  5 Same cycle: alloc + mispredict tag 1 -> alloc dropped, tail=1; recoverFlag_i with
//    mispredict -> flush wins, no pulse, cnt=0.
//  6 Reset asserted cycle after mispredict -> pulse suppressed, all state cleared.

Source files
------------

// File: rtl/free_list_checkpoint_ctrl_pkg.sv
// free_list_checkpoint_ctrl_pkg: shared sizing for the branch-checkpoint manager
package free_list_checkpoint_ctrl_pkg;
    localparam int NUM_CP = 8;
    localparam int CP_LOG = 3;
    localparam int FL_LOG = 7;
endpackage

// File: rtl/free_list_checkpoint_ctrl_cp_head_ram.sv
// cp_head_ram: reset-less free-list head store, one async read and one sync write
module cp_head_ram
    import free_list_checkpoint_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [CP_LOG-1:0] waddr,
    input  logic [FL_LOG-1:0] wdata,
    input  logic [CP_LOG-1:0] raddr,
    output logic [FL_LOG-1:0] rdata
);
    logic [FL_LOG-1:0] mem [NUM_CP];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/free_list_checkpoint_ctrl.sv
// free_list_checkpoint_ctrl: circular branch-checkpoint queue with single-cycle free-list recovery pulse
module free_list_checkpoint_ctrl
    import free_list_checkpoint_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              recoverFlag_i,
    input  logic              brAlloc_i,
    input  logic [FL_LOG-1:0] headAtBranch_i,
    input  logic              resolveValid_i,
    input  logic [CP_LOG-1:0] resolveTag_i,
    input  logic              mispredict_i,
    output logic [CP_LOG-1:0] cpTag_o,
    output logic              cpFull_o,
    output logic              ctrlVerified_o,
    output logic              flagRecoverEX_o,
    output logic [FL_LOG-1:0] freeListHeadCp_o,
    output logic [CP_LOG:0]   cpCount_o
);
    logic [CP_LOG-1:0] head, tail, age_t;
    logic [CP_LOG:0]   cnt;
    logic [NUM_CP-1:0] valid, kill;
    logic [FL_LOG-1:0] head_cp, ram_rd;
    logic              pulse, alloc, hit, mis, good, retire, we;
    assign cpFull_o = cnt == (CP_LOG+1)'(NUM_CP);
    assign cpTag_o = tail;
    assign cpCount_o = cnt;
    assign ctrlVerified_o = pulse;
    assign flagRecoverEX_o = pulse;
    assign freeListHeadCp_o = head_cp;
    assign alloc = brAlloc_i & ~stall_i & ~cpFull_o;
    assign hit = valid[resolveTag_i];
    assign mis = resolveValid_i & mispredict_i & hit;
    assign good = resolveValid_i & ~mispredict_i & hit;
    assign retire = (cnt != '0) & ~valid[head];
    assign we = alloc & reset & ~recoverFlag_i & ~mis;
    assign age_t = resolveTag_i - head;
    // squash every entry at least as young as the mispredicted one, measured from head
    always_comb begin
        kill = '0;
        for (int i = 0; i < NUM_CP; i++)
            kill[i] = CP_LOG'(CP_LOG'(i) - head) >= age_t;
    end
    cp_head_ram u_ram (
        .clk(clk),
        .we(we),
        .waddr(tail),
        .wdata(headAtBranch_i),
        .raddr(resolveTag_i),
        .rdata(ram_rd)
    );
    always_ff @(posedge clk) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt <= '0;
            valid <= '0;
            pulse <= 1'b0;
            head_cp <= '0;
        end else if (recoverFlag_i) begin
            head <= '0;
            tail <= '0;
            cnt <= '0;
            valid <= '0;
            pulse <= 1'b0;
        end else if (mis) begin
            tail <= resolveTag_i;
            cnt <= {1'b0, age_t};
            valid <= valid & ~kill;
            pulse <= 1'b1;
            head_cp <= ram_rd;
        end else begin
            pulse <= 1'b0;
            if (good) valid[resolveTag_i] <= 1'b0;
            if (alloc) valid[tail] <= 1'b1;
            tail <= tail + CP_LOG'(alloc);
            head <= head + CP_LOG'(retire);
            cnt <= cnt + {{CP_LOG{1'b0}}, alloc} - {{CP_LOG{1'b0}}, retire};
        end
    end
endmodule
